// File: rtl/alarm_sequencer.sv
// Intruder-alarm sequencer: exit delay, armed watch, entry delay and timed siren with
// automatic re-arm. Every output comes straight from a register.
module alarm_sequencer #(
  parameter int unsigned EXIT_CYCLES  = 8,
  parameter int unsigned ENTRY_CYCLES = 6,
  parameter int unsigned SIREN_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       disarm,
  input  logic       panic,
  input  logic       window,
  input  logic       door,
  input  logic       garage,
  output logic       alarm,
  output logic       armed,
  output logic [2:0] state,
  output logic [7:0] count,
  output logic [3:0] trips
);

  localparam logic [7:0] ExitLoad  = 8'(EXIT_CYCLES - 1);
  localparam logic [7:0] EntryLoad = 8'(ENTRY_CYCLES - 1);
  localparam logic [7:0] SirenLoad = 8'(SIREN_CYCLES - 1);

  typedef enum logic [2:0] {
    StDisarmed = 3'd0,
    StExit     = 3'd1,
    StArmed    = 3'd2,
    StEntry    = 3'd3,
    StAlarm    = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [3:0] trips_q, trips_d;
  logic       alarm_q, alarm_d;
  logic       armed_q, armed_d;
  logic       go_alarm;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    trips_d  = trips_q;
    go_alarm = 1'b0;

    if (panic) begin
      go_alarm = 1'b1;
    end else if (disarm && (state_q != StDisarmed)) begin
      state_d = StDisarmed;
      count_d = 8'd0;
      trips_d = 4'd0;
    end else begin
      case (state_q)
        StDisarmed: begin
          count_d = 8'd0;
          if (arm) begin
            state_d = StExit;
            count_d = ExitLoad;
          end
        end
        StExit: begin
          if (count_q == 8'd0) begin
            state_d = StArmed;
          end else begin
            count_d = count_q - 8'd1;
          end
        end
        StArmed: begin
          count_d = 8'd0;
          if (window) begin
            go_alarm = 1'b1;
          end else if (door || garage) begin
            state_d = StEntry;
            count_d = EntryLoad;
          end
        end
        StEntry: begin
          // Closing door/garage does not cancel: only window or expiry change state here.
          if (window || (count_q == 8'd0)) begin
            go_alarm = 1'b1;
          end else begin
            count_d = count_q - 8'd1;
          end
        end
        StAlarm: begin
          if (count_q == 8'd0) begin
            state_d = StArmed;
          end else begin
            count_d = count_q - 8'd1;
          end
        end
        default: begin
          state_d = StDisarmed;
          count_d = 8'd0;
        end
      endcase
    end

    // Re-loading the siren from inside ALARM is not a new trip.
    if (go_alarm) begin
      state_d = StAlarm;
      count_d = SirenLoad;
      if ((state_q != StAlarm) && (trips_q != 4'hF)) begin
        trips_d = trips_q + 4'd1;
      end
    end

    alarm_d = (state_d == StAlarm);
    armed_d = (state_d == StArmed) || (state_d == StEntry) || (state_d == StAlarm);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StDisarmed;
      count_q <= 8'd0;
      trips_q <= 4'd0;
      alarm_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      trips_q <= trips_d;
      alarm_q <= alarm_d;
      armed_q <= armed_d;
    end
  end

  assign alarm = alarm_q;
  assign armed = armed_q;
  assign state = state_q;
  assign count = count_q;
  assign trips = trips_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Scoreboarded bench for alarm_sequencer with short delays (exit 4, entry 3, siren 5).
module tb_alarm_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm, disarm, panic, window, door, garage;
  logic       alarm, armed;
  logic [2:0] state;
  logic [7:0] count;
  logic [3:0] trips;

  int errors = 0;
  int checks = 0;

  // Input bit order: {arm, disarm, panic, window, door, garage}.
  localparam logic [5:0] I_NONE = 6'b000000;
  localparam logic [5:0] I_ARM  = 6'b100000;
  localparam logic [5:0] I_DIS  = 6'b010000;
  localparam logic [5:0] I_PAN  = 6'b001000;
  localparam logic [5:0] I_WIN  = 6'b000100;
  localparam logic [5:0] I_DOOR = 6'b000010;
  localparam logic [5:0] I_GAR  = 6'b000001;

  typedef struct packed {
    logic [5:0] in;
    logic [2:0] st;
    logic [7:0] cnt;
    logic [3:0] tr;
  } step_t;

  step_t sb_q[$];

  alarm_sequencer #(
    .EXIT_CYCLES (4),
    .ENTRY_CYCLES(3),
    .SIREN_CYCLES(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arm   (arm),
    .disarm(disarm),
    .panic (panic),
    .window(window),
    .door  (door),
    .garage(garage),
    .alarm (alarm),
    .armed (armed),
    .state (state),
    .count (count),
    .trips (trips)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // Queue the inputs for one cycle and the outputs expected just after that edge.
  task automatic push(input logic [5:0] in, input logic [2:0] st, input logic [7:0] cnt,
                      input logic [3:0] tr);
    step_t s;
    s.in = in; s.st = st; s.cnt = cnt; s.tr = tr;
    sb_q.push_back(s);
  endtask

  task automatic drive(input logic [5:0] in);
    {arm, disarm, panic, window, door, garage} = in;
  endtask

  function automatic logic [17:0] expect_vec(input step_t s);
    logic a, r;
    a = (s.st == 3'd4);
    r = (s.st == 3'd2) || (s.st == 3'd3) || (s.st == 3'd4);
    return {a, r, s.st, s.cnt, s.tr};
  endfunction

  task automatic push_arm_sequence(input logic [5:0] extra, input logic [3:0] tr);
    push(I_ARM | extra, 3'd1, 8'd3, tr);
    push(extra, 3'd1, 8'd2, tr);
    push(extra, 3'd1, 8'd1, tr);
    push(extra, 3'd1, 8'd0, tr);
    push(extra, 3'd2, 8'd0, tr);
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    rst_n = 1'b0;
    drive(I_NONE);
    #12;
    obs = {alarm, armed, state, count, trips};
    checks++;
    if (obs !== 18'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs, 18'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arm();
    step_t s;
    logic [17:0] obs;
    push_arm_sequence(I_NONE, 4'd0);
    push(I_NONE, 3'd2, 8'd0, 4'd0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      drive(s.in);
      @(posedge clk); #1;
      obs = {alarm, armed, state, count, trips};
      checks++;
      if (obs !== expect_vec(s)) begin
        errors++;
        $display("FAIL arm_idle: got %h expected %h", obs, expect_vec(s));
      end
    end
  endtask

  task automatic test_entry();
    step_t s;
    logic [17:0] obs;
    push(I_DOOR, 3'd3, 8'd2, 4'd0);
    push(I_NONE, 3'd3, 8'd1, 4'd0);
    push(I_NONE, 3'd3, 8'd0, 4'd0);
    push(I_NONE, 3'd4, 8'd4, 4'd1);
    for (int c = 3; c >= 0; c--) push(I_NONE, 3'd4, 8'(c), 4'd1);
    push(I_NONE, 3'd2, 8'd0, 4'd1);
    // Garage path, then window cuts the entry delay short.
    push(I_GAR, 3'd3, 8'd2, 4'd1);
    push(I_WIN, 3'd4, 8'd4, 4'd2);
    push(I_DIS, 3'd0, 8'd0, 4'd0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      drive(s.in);
      @(posedge clk); #1;
      obs = {alarm, armed, state, count, trips};
      checks++;
      if (obs !== expect_vec(s)) begin
        errors++;
        $display("FAIL entry_path: got %h expected %h", obs, expect_vec(s));
      end
    end
  endtask

  task automatic test_entry_disarm();
    step_t s;
    logic [17:0] obs;
    bit saw_alarm = 0;
    push_arm_sequence(I_NONE, 4'd0);
    push(I_DOOR, 3'd3, 8'd2, 4'd0);
    push(I_DIS, 3'd0, 8'd0, 4'd0);
    push(I_NONE, 3'd0, 8'd0, 4'd0);
    push(I_NONE, 3'd0, 8'd0, 4'd0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      drive(s.in);
      @(posedge clk); #1;
      if (alarm === 1'b1) saw_alarm = 1;
      obs = {alarm, armed, state, count, trips};
      checks++;
      if (obs !== expect_vec(s)) begin
        errors++;
        $display("FAIL entry_disarm: got %h expected %h", obs, expect_vec(s));
      end
    end
    checks++;
    if (saw_alarm) begin
      errors++;
      $display("FAIL entry_disarm_no_alarm: got alarm=1 expected alarm never 1");
    end
  endtask

  task automatic test_priority();
    step_t s;
    logic [17:0] obs;
    push_arm_sequence(I_NONE, 4'd0);
    push(I_DOOR, 3'd3, 8'd2, 4'd0);
    push(I_PAN | I_DIS, 3'd4, 8'd4, 4'd1);
    push(I_NONE, 3'd4, 8'd3, 4'd1);
    push(I_PAN, 3'd4, 8'd4, 4'd1);
    push(I_DIS, 3'd0, 8'd0, 4'd0);
    push(I_PAN, 3'd4, 8'd4, 4'd1);
    push(I_DIS | I_ARM, 3'd0, 8'd0, 4'd0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      drive(s.in);
      @(posedge clk); #1;
      obs = {alarm, armed, state, count, trips};
      checks++;
      if (obs !== expect_vec(s)) begin
        errors++;
        $display("FAIL priority: got %h expected %h", obs, expect_vec(s));
      end
    end
  endtask

  task automatic test_window_saturate();
    step_t s;
    logic [17:0] obs;
    logic [3:0] tr;
    push_arm_sequence(I_WIN, 4'd0);
    for (int k = 1; k <= 16; k++) begin
      tr = (k > 15) ? 4'd15 : 4'(k);
      push(I_WIN, 3'd4, 8'd4, tr);
      for (int c = 3; c >= 0; c--) push(I_WIN, 3'd4, 8'(c), tr);
      push(I_WIN, 3'd2, 8'd0, tr);
    end
    push(I_WIN | I_DIS, 3'd0, 8'd0, 4'd0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      drive(s.in);
      @(posedge clk); #1;
      obs = {alarm, armed, state, count, trips};
      checks++;
      if (obs !== expect_vec(s)) begin
        errors++;
        $display("FAIL window_trips: got %h expected %h", obs, expect_vec(s));
      end
    end
  endtask

  task automatic test_async_reset();
    step_t s;
    logic [17:0] obs;
    push(I_PAN, 3'd4, 8'd4, 4'd1);
    push(I_NONE, 3'd4, 8'd3, 4'd1);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      drive(s.in);
      @(posedge clk); #1;
      obs = {alarm, armed, state, count, trips};
      checks++;
      if (obs !== expect_vec(s)) begin
        errors++;
        $display("FAIL async_setup: got %h expected %h", obs, expect_vec(s));
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {alarm, armed, state, count, trips};
    checks++;
    if (obs !== 18'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", obs, 18'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(I_ARM, 3'd1, 8'd3, 4'd0);
    while (sb_q.size() > 0) begin
      s = sb_q.pop_front();
      drive(s.in);
      @(posedge clk); #1;
      obs = {alarm, armed, state, count, trips};
      checks++;
      if (obs !== expect_vec(s)) begin
        errors++;
        $display("FAIL post_reset_edge: got %h expected %h", obs, expect_vec(s));
      end
    end
    drive(I_NONE);
  endtask

  initial begin
    test_reset();
    test_arm();
    test_entry();
    test_entry_disarm();
    test_priority();
    test_window_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
